// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared state type, direction codes and width default for the shift arbiter
package shift_arb_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  localparam int DEF_DATAWIDTH = 64;
endpackage

// File: rtl/shift_unit.sv
// shift_unit: combinational logical shifter, zero result once the amount reaches the width
module shift_unit import shift_arb_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_amt,
  input  logic                 i_dir,
  output logic [DATAWIDTH-1:0] o_d
);
  localparam logic [DATAWIDTH-1:0] W = DATAWIDTH'(DATAWIDTH);
  // full-width compare catches any set upper amount bit as an overflow
  always_comb o_d = (i_amt >= W) ? '0 : (i_dir == DIR_LEFT) ? i_a << i_amt : i_a >> i_amt;
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbitration of NREQ requesters onto one shifter, one result in flight
module shift_arbiter import shift_arb_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_amt,
  input  logic [NREQ-1:0]           req_dir,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [DATAWIDTH-1:0]      rsp_d,
  input  logic                      rsp_ready
);
  state_t r_state;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_gnt;
  logic w_found;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_amt;
  logic r_dir;
  logic [DATAWIDTH-1:0] w_d;
  // first valid requester after the previous grant, wrapping back to it last
  always_comb begin
    w_found = 1'b0;
    w_gnt = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[IDW'((int'(r_last) + k) % NREQ)]) begin
        w_found = 1'b1;
        w_gnt = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end
  // accept strobe only while idle and out of reset
  always_comb req_ready = (r_state == IDLE && !Rst && w_found) ? NREQ'(1) << w_gnt : '0;
  shift_unit #(.DATAWIDTH(DATAWIDTH)) u_shift (
    .i_a(r_a),
    .i_amt(r_amt),
    .i_dir(r_dir),
    .o_d(w_d)
  );
  // latch the granted operands, register the shift, hold the result until consumed
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_d <= '0;
      rsp_id <= '0;
      r_last <= IDW'(NREQ - 1);
      r_id <= '0;
      r_a <= '0;
      r_amt <= '0;
      r_dir <= DIR_RIGHT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a <= req_a[w_gnt*DATAWIDTH +: DATAWIDTH];
            r_amt <= req_amt[w_gnt*DATAWIDTH +: DATAWIDTH];
            r_dir <= req_dir[w_gnt];
            r_id <= w_gnt;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_d <= w_d;
          rsp_id <= r_id;
          r_last <= r_id;
          rsp_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a queue-based response scoreboard
module tb_shift_arbiter;
  localparam int DW = 64;
  localparam int N = 4;
  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] d;
  } exp_t;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [N-1:0] req_valid = '1;
  logic [N-1:0] req_dir = '0;
  logic [N-1:0] req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_amt = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [DW-1:0] rsp_d;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t q[$];
  shift_arbiter #(.DATAWIDTH(DW), .NREQ(N)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_amt(req_amt),
    .req_dir(req_dir),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_d(rsp_d),
    .rsp_ready(rsp_ready)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] amt, input logic dir);
    req_a[i*DW +: DW] = a;
    req_amt[i*DW +: DW] = amt;
    req_dir[i] = dir;
  endtask
  task automatic wait_grant();
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (req_ready != 0) break;
    end
  endtask
  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0) break;
      @(negedge Clk);
    end
    chk("drain_empty", DW'(q.size()), 0);
  endtask
  task automatic single(input int id, input logic [DW-1:0] a, input logic [DW-1:0] amt,
                        input logic dir, input logic [DW-1:0] exp, input string nm);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    @(posedge Clk);
    #1;
    set_op(id, a, amt, dir);
    req_valid = oh;
    q.push_back('{id: 2'(id), d: exp});
    wait_grant();
    chk({nm, "_gnt"}, DW'(req_ready), DW'(oh));
    @(posedge Clk);
    #1;
    req_valid = '0;
    drain();
  endtask
  task automatic do_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    req_valid = '1;
    @(negedge Clk);
    chk("rst_ready", DW'(req_ready), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    req_valid = '0;
  endtask
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    int last_cyc;
    fork
      forever begin
        @(negedge Clk);
        if (!Rst && rsp_valid && rsp_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp got id=%0d d=%h want none", rsp_id, rsp_d);
          end else begin
            e = q.pop_front();
            chk("rsp_id", DW'(rsp_id), DW'(e.id));
            chk("rsp_d", rsp_d, e.d);
          end
        end
      end
      begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
      end
    join_none
    repeat (2) begin
      @(negedge Clk);
      chk("rst_ready_hold", DW'(req_ready), 0);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    req_valid = '0;
    @(negedge Clk);
    chk("rst_valid", DW'(rsp_valid), 0);
    chk("rst_d", rsp_d, 0);
    chk("rst_id", DW'(rsp_id), 0);
    @(posedge Clk);
    #1;
    set_op(0, 64'hF0, 64'd4, 1'b0);
    req_valid = 4'b0001;
    q.push_back('{id: 2'd0, d: 64'h0F});
    @(negedge Clk);
    chk("t1_gnt", DW'(req_ready), 64'b0001);
    @(posedge Clk);
    #1;
    req_valid = '0;
    @(negedge Clk);
    chk("t1_lat_n1", DW'(rsp_valid), 0);
    @(negedge Clk);
    chk("t1_lat_n2", DW'(rsp_valid), 1);
    drain();
    single(1, '1, 64'd64, 1'b0, 64'h0, "ovf64_r");
    single(2, '1, 64'd64, 1'b1, 64'h0, "ovf64_l");
    single(3, '1, 64'h1_0000_0000, 1'b0, 64'h0, "ovfhi_r");
    single(0, '1, 64'h1_0000_0000, 1'b1, 64'h0, "ovfhi_l");
    single(1, 64'h1, 64'd63, 1'b1, 64'h8000_0000_0000_0000, "l63");
    single(2, '1, 64'd63, 1'b0, 64'h1, "r63");
    single(3, 64'h1234, 64'd8, 1'b1, 64'h12_3400, "l8");
    single(0, 64'hDEAD_BEEF, 64'd0, 1'b0, 64'hDEAD_BEEF, "amt0");
    @(posedge Clk);
    #1;
    rsp_ready = 1'b0;
    set_op(3, 64'hABCD, 64'd4, 1'b1);
    req_valid = 4'b1000;
    q.push_back('{id: 2'd3, d: 64'hA_BCD0});
    wait_grant();
    chk("bp_gnt", DW'(req_ready), 64'b1000);
    @(posedge Clk);
    #1;
    req_valid = '1;
    @(negedge Clk);
    chk("bp_shift_ready", DW'(req_ready), 0);
    repeat (5) begin
      @(negedge Clk);
      chk("bp_valid", DW'(rsp_valid), 1);
      chk("bp_d", rsp_d, 64'hA_BCD0);
      chk("bp_id", DW'(rsp_id), 3);
      chk("bp_ready", DW'(req_ready), 0);
    end
    @(posedge Clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge Clk);
    #1;
    set_op(0, 64'h10, 64'd4, 1'b0);
    req_valid = 4'b0001;
    q.push_back('{id: 2'd0, d: 64'h1});
    @(negedge Clk);
    chk("bp_idle_valid", DW'(rsp_valid), 0);
    chk("bp_idle_gnt", DW'(req_ready), 64'b0001);
    @(posedge Clk);
    #1;
    req_valid = '0;
    drain();
    @(posedge Clk);
    #1;
    set_op(1, 64'h5555, 64'd1, 1'b0);
    req_valid = 4'b0010;
    wait_grant();
    chk("mid_gnt", DW'(req_ready), 64'b0010);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    req_valid = '0;
    @(negedge Clk);
    chk("mid_rst_ready", DW'(req_ready), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    set_op(0, 64'h8, 64'd3, 1'b0);
    set_op(2, 64'h8, 64'd1, 1'b0);
    req_valid = '1;
    @(negedge Clk);
    chk("mid_valid", DW'(rsp_valid), 0);
    chk("mid_first_gnt", DW'(req_ready), 64'b0001);
    q.push_back('{id: 2'd0, d: 64'h1});
    @(posedge Clk);
    #1;
    req_valid = '0;
    drain();
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 64'hFF00, 64'(i), 1'b0);
    q.push_back('{id: 2'd0, d: 64'hFF00});
    q.push_back('{id: 2'd1, d: 64'h7F80});
    q.push_back('{id: 2'd2, d: 64'h3FC0});
    q.push_back('{id: 2'd3, d: 64'h1FE0});
    q.push_back('{id: 2'd0, d: 64'hFF00});
    req_valid = '1;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant();
      oh = N'(1) << (g % N);
      chk("rr_gnt", DW'(req_ready), DW'(oh));
      if (g > 0) chk("rr_gap", DW'(cyc - last_cyc), 3);
      last_cyc = cyc;
    end
    @(posedge Clk);
    #1;
    req_valid = '0;
    drain();
    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 64, operand/result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; IDW = clog2(NREQ).
REQ-003 Clk  input  1  rising-edge clock, single clock domain.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_a  input  NREQ*DATAWIDTH  operand; requester i at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-007 req_amt  input  NREQ*DATAWIDTH  shift amount, same packing as req_a.
REQ-008 req_dir  input  NREQ  direction per requester: 0 = logical right, 1 = logical left.
REQ-009 req_ready  output  NREQ  one-hot accept strobe; bit i high means requester i is accepted this cycle.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_d  output  DATAWIDTH  shift result.
REQ-013 rsp_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states: IDLE, SHIFT, RESP.
REQ-015 IDLE with any req_valid: grant one requester round-robin, starting the search at last_grant+1 modulo NREQ; assert req_ready for the granted bit only, combinationally in that cycle; latch a, amt, dir and id; go to SHIFT.
REQ-016 IDLE with no req_valid: req_ready = 0; stay in IDLE; last_grant unchanged.
REQ-017 SHIFT: register shift_unit output into rsp_d and the latched id into rsp_id; update last_grant; go to RESP.
REQ-018 RESP: rsp_valid = 1; rsp_d and rsp_id held stable until rsp_ready.
REQ-019 RESP with rsp_ready: the transfer completes that cycle; go to IDLE next cycle.
REQ-020 Latency: a request accepted in cycle N gives rsp_valid in cycle N+2; minimum issue interval is 3 cycles.
REQ-021 req_ready = 0 in SHIFT and RESP; requests are never accepted while a result is outstanding.
REQ-022 Right shift: rsp_d = a >> amt (zero fill). Left shift: rsp_d = a << amt (zero fill).
REQ-023 amt >= DATAWIDTH, including any upper bit of amt being set: rsp_d = 0.
REQ-024 A requester that deasserts req_valid before it is granted is skipped without side effects.
REQ-025 Requesters hold req_valid and their operands stable until they see their req_ready bit.
REQ-026 When all NREQ requesters are valid continuously, each is granted exactly once per NREQ grants.

Reset
REQ-027 Rst held high at a rising Clk edge: state = IDLE, rsp_valid = 0, rsp_d = 0, rsp_id = 0, last_grant = NREQ-1 so requester 0 has first priority.
REQ-028 Reset asserted in SHIFT or RESP discards the in-flight operation; no result is produced for it.
REQ-029 req_ready = 0 during every cycle in which Rst is high.

Structure
REQ-030 Shared package shift_arb_pkg holds the state enum (IDLE, SHIFT, RESP), the direction constants DIR_RIGHT = 0 and DIR_LEFT = 1, and the DATAWIDTH default.
REQ-031 One sub-module, shift_unit: a combinational bidirectional shifter (a, amt, dir -> d) implementing REQ-022 and REQ-023; no other sub-modules.
REQ-032 The round-robin arbiter and the FSM are implemented inside shift_arbiter.

Verification
REQ-033 Single request, idle arbiter: after reset, req_valid = 0001, a = 0xF0, amt = 4, dir = 0 -> req_ready = 0001 in cycle N; rsp_valid in cycle N+2 with rsp_d = 0x0F, rsp_id = 0.
REQ-034 Round-robin fairness: req_valid = 1111 held, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, with grants 3 cycles apart.
REQ-035 Shift overflow: amt = 64, and separately amt = 0x1_0000_0000, with a = all ones, both directions -> rsp_d = 0.
REQ-036 Backpressure: rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_d and rsp_id stable; req_ready = 0 throughout; on rsp_ready = 1 the FSM returns to IDLE the next cycle.
REQ-037 Reset mid-operation: Rst asserted in SHIFT -> next cycle rsp_valid = 0 and state = IDLE; a subsequent request from requester 2 with all valid is granted to requester 0 first.
REQ-038 Left shift: a = 1, amt = 63, dir = 1 -> rsp_d = 0x8000_0000_0000_0000.
